// File: rtl/board_state_tx_if.sv
// Byte stream from board_state_tx toward the host socket adapter.
// Plain valid/ready handshake; a byte moves on any clock where both are high.
interface board_state_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/board_state_tx.sv
// Snapshots LED/HEX board outputs and streams them as 10-byte frames
// (A5, LED lo, LED hi, HEX0..HEX5, XOR checksum) on change, after reset and on keep-alive.
module board_state_tx #(
    parameter int unsigned KEEPALIVE = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [9:0]       LED,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    input  logic [6:0]       HEX2,
    input  logic [6:0]       HEX3,
    input  logic [6:0]       HEX4,
    input  logic [6:0]       HEX5,
    board_state_tx_if.master tx,
    output logic             BUSY
);

    localparam int unsigned    CNT_W  = (KEEPALIVE == 0) ? 1 : $clog2(KEEPALIVE + 1);
    localparam logic [CNT_W-1:0] KA_MAX = CNT_W'(KEEPALIVE);
    localparam bit             KA_EN  = (KEEPALIVE != 0);

    typedef struct packed {
        logic [6:0] hex5;
        logic [6:0] hex4;
        logic [6:0] hex3;
        logic [6:0] hex2;
        logic [6:0] hex1;
        logic [6:0] hex0;
        logic [9:0] led;
    } snap_t;

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e           state_q, state_d;
    snap_t            snap_q, snap_d;
    snap_t            live;
    logic             force_q, force_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [3:0]       idx_q, idx_d;
    logic             trigger;
    logic [7:0]       frame [10];

    assign live = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LED};

    // Frame bytes come from the held snapshot only, so live inputs may move mid-frame.
    always_comb begin
        frame[0] = 8'hA5;
        frame[1] = snap_q.led[7:0];
        frame[2] = {6'b0, snap_q.led[9:8]};
        frame[3] = {1'b0, snap_q.hex0};
        frame[4] = {1'b0, snap_q.hex1};
        frame[5] = {1'b0, snap_q.hex2};
        frame[6] = {1'b0, snap_q.hex3};
        frame[7] = {1'b0, snap_q.hex4};
        frame[8] = {1'b0, snap_q.hex5};
        frame[9] = frame[1] ^ frame[2] ^ frame[3] ^ frame[4]
                 ^ frame[5] ^ frame[6] ^ frame[7] ^ frame[8];
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        force_d = force_q;
        idle_d  = idle_q;
        idx_d   = idx_q;
        trigger = 1'b0;
        case (state_q)
            S_IDLE: begin
                trigger = force_q || (live != snap_q) || (KA_EN && (idle_q == KA_MAX));
                if (trigger) begin
                    snap_d  = live;
                    force_d = 1'b0;
                    idle_d  = '0;
                    idx_d   = 4'd0;
                    state_d = S_SEND;
                end else if (idle_q != KA_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_SEND: begin
                if (tx.TX_READY) begin
                    if (idx_q == 4'd9) state_d = S_IDLE;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid is pure state, keeping TX_READY out of any path to TX_VALID.
    assign tx.TX_VALID = (state_q == S_SEND);
    assign tx.TX_DATA  = (state_q == S_SEND) ? frame[idx_q] : 8'h00;
    assign BUSY        = (state_q == S_SEND);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            force_q <= 1'b1;
            idle_q  <= '0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            force_q <= force_d;
            idle_q  <= idle_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_board_state_tx.sv
// Directed bench for board_state_tx: frame contents, handshake hold, mid-frame change,
// keep-alive period (second instance, KEEPALIVE=16) and reset mid-frame.
module tb_board_state_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] led = '0;
    logic [6:0] hex0 = '0, hex1 = '0, hex2 = '0, hex3 = '0, hex4 = '0, hex5 = '0;
    logic       busy0, busy1;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    board_state_tx_if tx0 ();
    board_state_tx_if tx1 ();

    board_state_tx #(.KEEPALIVE(0)) dut0 (
        .CLK(clk), .RST(rst), .LED(led),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .tx(tx0.master), .BUSY(busy0)
    );

    board_state_tx #(.KEEPALIVE(16)) dut1 (
        .CLK(clk), .RST(rst), .LED(led),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .tx(tx1.master), .BUSY(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collects one frame from dut0 (first byte accepted is byte 0); bytes shift in so the
    // result reads as 80'hB0_B1_..._B9. chg_at sets HEX5=0x12 while that byte index is on the bus.
    task automatic recv_frame(input bit rnd, input int chg_at, output logic [79:0] f,
                              output int hdr_c, output int last_c);
        int         n = 0;
        int         t = 0;
        logic [7:0] pd = '0;
        bit         pstall = 1'b0;
        f = '0; hdr_c = -1; last_c = -1;
        while (n < 10 && t < 400) begin
            @(negedge clk); t++;
            if (pstall) begin
                n_assert++;
                if (!(tx0.TX_VALID === 1'b1 && tx0.TX_DATA === pd)) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b data=%02h, required valid=1 data=%02h",
                             tx0.TX_VALID, tx0.TX_DATA, pd);
                end
            end
            n_assert++;
            if (busy0 !== tx0.TX_VALID) begin
                n_fail++;
                $display("FAIL busy: busy=%b, required %b", busy0, tx0.TX_VALID);
            end
            tx0.TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx0.TX_VALID === 1'b1) begin
                if (n == chg_at) hex5 = 7'h12;
                if (tx0.TX_READY) begin
                    f = {f[71:0], tx0.TX_DATA};
                    if (n == 0) hdr_c = cyc;
                    if (n == 9) last_c = cyc;
                    n++;
                end
            end
            pstall = tx0.TX_VALID && !tx0.TX_READY;
            pd     = tx0.TX_DATA;
        end
        tx0.TX_READY = 1'b1;
        if (n < 10) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d bytes, required 10", n);
        end
    endtask

    task automatic check_frame(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %020h, required %020h", name, got, exp);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx0.TX_VALID !== 1'b0) seen = 1'b1;
        end
        n_assert++;
        if (seen) begin
            n_fail++;
            $display("FAIL %s: TX_VALID rose while idle, required 0", name);
        end
    endtask

    task automatic test_reset();
        logic [79:0] f;
        int          h, l, c0;
        tx0.TX_READY = 1'b1;
        tx1.TX_READY = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert += 3;
        if (tx0.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", tx0.TX_VALID); end
        if (tx0.TX_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h, required 00", tx0.TX_DATA); end
        if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy0); end
        c0  = cyc;
        rst = 1'b0;
        recv_frame(1'b0, -1, f, h, l);
        n_assert++;
        if (h != c0 + 1) begin n_fail++; $display("FAIL rst_latency: header at %0d, required %0d", h, c0 + 1); end
        check_frame("rst_frame", f, 80'hA5_00_00_00_00_00_00_00_00_00);
        check_quiet("rst_quiet", 20);
    endtask

    task automatic test_static();
        logic [79:0] f;
        int          h, l;
        led  = 10'h3FF;
        hex0 = 7'h7F;
        recv_frame(1'b0, -1, f, h, l);
        check_frame("static_frame", f, 80'hA5_FF_03_7F_00_00_00_00_00_83);
        check_quiet("static_quiet", 30);
    endtask

    task automatic test_random_ready();
        logic [79:0] f;
        int          h, l;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        recv_frame(1'b1, -1, f, h, l);
        check_frame("rand_ready_frame", f, 80'hA5_FF_03_7F_00_00_00_00_00_83);
        check_quiet("rand_ready_quiet", 10);
    endtask

    task automatic test_back_to_back();
        logic [79:0] f;
        int          h1, l1, h2, l2;
        led  = 10'h001;
        hex0 = 7'h00;
        recv_frame(1'b0, 4, f, h1, l1);
        check_frame("midchg_first", f, 80'hA5_01_00_00_00_00_00_00_00_01);
        recv_frame(1'b0, -1, f, h2, l2);
        check_frame("midchg_second", f, 80'hA5_01_00_00_00_00_00_00_12_13);
        n_assert += 2;
        if (h2 != l1 + 2)  begin n_fail++; $display("FAIL b2b_gap: header at %0d, required %0d", h2, l1 + 2); end
        if (h2 != h1 + 11) begin n_fail++; $display("FAIL b2b_period: %0d, required 11", h2 - h1); end
    endtask

    task automatic test_keepalive();
        int  hdr [3];
        int  k = 0;
        int  t = 0;
        bit  pv = 1'b1;
        while (k < 3 && t < 200) begin
            @(negedge clk); t++;
            if (tx1.TX_VALID === 1'b1 && !pv && tx1.TX_DATA === 8'hA5) begin
                hdr[k] = cyc;
                k++;
            end
            pv = tx1.TX_VALID;
        end
        n_assert++;
        if (k < 3) begin
            n_fail++;
            $display("FAIL ka_timeout: saw %0d headers, required 3", k);
        end else begin
            n_assert++;
            if (hdr[1] - hdr[0] != 27 || hdr[2] - hdr[1] != 27) begin
                n_fail++;
                $display("FAIL ka_period: %0d,%0d, required 27,27", hdr[1] - hdr[0], hdr[2] - hdr[1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [79:0] f;
        int          h, l, c0;
        int          n = 0;
        int          t = 0;
        bit          hit = 1'b0;
        led = 10'h2AA;
        while (!hit && t < 40) begin
            @(negedge clk); t++;
            if (tx0.TX_VALID === 1'b1) begin
                if (n == 5) begin rst = 1'b1; hit = 1'b1; end
                n++;
            end
        end
        n_assert++;
        if (!hit) begin n_fail++; $display("FAIL rstmid_reach: byte 5 not seen, required seen"); end
        @(negedge clk);
        n_assert += 2;
        if (tx0.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", tx0.TX_VALID); end
        if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy0); end
        c0  = cyc;
        rst = 1'b0;
        recv_frame(1'b0, -1, f, h, l);
        n_assert++;
        if (h != c0 + 1) begin n_fail++; $display("FAIL rstmid_latency: header at %0d, required %0d", h, c0 + 1); end
        check_frame("rstmid_frame", f, 80'hA5_AA_02_00_00_00_00_00_12_BA);
    endtask

    initial begin
        test_reset();
        test_static();
        test_random_ready();
        test_back_to_back();
        test_keepalive();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
